// File: rtl/encoder4to2_rr.sv
// Pulse-request encoder: latches request pulses on four lines and grants them one at a
// time through a registered valid/ready port, with round-robin or fixed-priority selection.
module encoder4to2_rr #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D,
  input  logic       ready,
  output logic [1:0] A,
  output logic       valid,
  output logic [2:0] cnt,
  output logic       multi,
  output logic       ovf
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_pend;
  logic [1:0] r_ptr;
  logic [1:0] r_a;
  logic       r_ovf;
  logic       w_hs;
  logic [3:0] w_clr;
  logic [3:0] w_rem;
  logic [1:0] w_ptr_sel;
  logic [1:0] w_a_nxt;

  // Round-robin scans ptr, ptr+1, ... (2-bit wrap); fixed mode lets the highest index win.
  function automatic logic [1:0] f_sel(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    f_sel = 2'd0;
    found = 1'b0;
    if (RR_EN != 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = ptr + 2'(k);
        if (!found && req[idx]) begin
          f_sel = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (req[k]) f_sel = 2'(k);
    end
  endfunction

  assign w_hs      = (r_state == S_GRANT) && ready;
  assign w_clr     = w_hs ? (4'b0001 << r_a) : 4'b0000;
  assign w_rem     = r_pend & ~w_clr;
  // Selection after a handshake uses the pointer value that the handshake produces.
  assign w_ptr_sel = w_hs ? (r_a + 2'd1) : r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 4'b0000) begin
          w_state_nxt = S_GRANT;
          w_a_nxt     = f_sel(r_pend, r_ptr);
        end
      end
      S_GRANT: begin
        if (ready) begin
          if (w_rem != 4'b0000) w_a_nxt = f_sel(w_rem, w_ptr_sel);
          else                  w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new pulse on a line that is still pending (and not leaving) is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 4'b0000;
      r_ptr  <= 2'd0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_rem | D;
      if (w_hs)              r_ptr <= r_a + 2'd1;
      if ((D & w_rem) != 0)  r_ovf <= 1'b1;
    end
  end

  always_comb begin
    valid = (r_state == S_GRANT);
    A     = r_a;
    ovf   = r_ovf;
    cnt   = 3'd0;
    for (int k = 0; k < 4; k++) cnt = cnt + 3'(r_pend[k]);
    multi = (cnt > 3'd1);
  end

endmodule

// File: tb/tb_encoder4to2_rr.sv
// Scoreboarded bench: one round-robin and one fixed-priority instance; expected grant
// indices are queued at stimulus time and popped by a monitor on every handshake.
module tb_encoder4to2_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] D_rr = 4'b0, D_fx = 4'b0;
  logic       ready_rr = 1'b0, ready_fx = 1'b0;
  logic [1:0] A_rr, A_fx;
  logic       valid_rr, valid_fx, multi_rr, multi_fx, ovf_rr, ovf_fx;
  logic [2:0] cnt_rr, cnt_fx;

  int nvec = 0;
  int nerr = 0;
  int q_rr[$];
  int q_fx[$];

  always #5 clk = ~clk;

  encoder4to2_rr #(.RR_EN(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .D(D_rr), .ready(ready_rr),
    .A(A_rr), .valid(valid_rr), .cnt(cnt_rr), .multi(multi_rr), .ovf(ovf_rr));

  encoder4to2_rr #(.RR_EN(0)) u_fx (
    .clk(clk), .rst_n(rst_n), .D(D_fx), .ready(ready_fx),
    .A(A_fx), .valid(valid_fx), .cnt(cnt_fx), .multi(multi_fx), .ovf(ovf_fx));

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake is visible mid-cycle as valid & ready.
  always @(negedge clk) begin
    if (rst_n && valid_rr && ready_rr) begin
      if (q_rr.size() == 0) chk("rr_unexpected_grant", 1, 0);
      else chk("rr_grant_A", int'(A_rr), q_rr.pop_front());
    end
    if (rst_n && valid_fx && ready_fx) begin
      if (q_fx.size() == 0) chk("fx_unexpected_grant", 1, 0);
      else chk("fx_grant_A", int'(A_fx), q_fx.pop_front());
    end
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_valid", int'(valid_rr), 0);
    chk("rst_A", int'(A_rr), 0);
    chk("rst_cnt", int'(cnt_rr), 0);
    chk("rst_multi", int'(multi_rr), 0);
    chk("rst_ovf", int'(ovf_rr), 0);
    chk("rst_valid_fx", int'(valid_fx), 0);
    rst_n = 1'b1;

    // Single request, latency k+1
    D_rr = 4'b0100; ready_rr = 1'b1; q_rr.push_back(2);
    tick(); D_rr = 4'b0;
    chk("single_valid_k", int'(valid_rr), 0);
    chk("single_cnt_k", int'(cnt_rr), 1);
    tick();
    chk("single_valid_k1", int'(valid_rr), 1);
    chk("single_A_k1", int'(A_rr), 2);
    chk("single_cnt_held", int'(cnt_rr), 1);
    tick();
    chk("single_valid_off", int'(valid_rr), 0);
    chk("single_cnt_zero", int'(cnt_rr), 0);

    // Round-robin order from ptr=3 (after granting 2): 0,1,2,3 expected? ptr=3 -> 3,0,1,2
    D_rr = 4'b1111; q_rr.push_back(3); q_rr.push_back(0); q_rr.push_back(1); q_rr.push_back(2);
    tick(); D_rr = 4'b0;
    chk("rr4_cnt", int'(cnt_rr), 4);
    chk("rr4_multi", int'(multi_rr), 1);
    repeat (4) tick();
    tick();
    chk("rr4_idle", int'(valid_rr), 0);
    // ptr now 3 again; grant 3 -> ptr wraps to 0, then full sweep 0,1,2,3
    D_rr = 4'b1000; q_rr.push_back(3);
    tick(); D_rr = 4'b0; tick(); tick();
    D_rr = 4'b1111; q_rr.push_back(0); q_rr.push_back(1); q_rr.push_back(2); q_rr.push_back(3);
    tick(); D_rr = 4'b0;
    tick();
    chk("rr_wrap_first_A", int'(A_rr), 0);
    repeat (3) tick();
    tick();
    chk("rr_sweep_idle", int'(valid_rr), 0);
    chk("rr_sweep_cnt", int'(cnt_rr), 0);
    // ptr=0: 1001 -> 0 then 3; then ptr=0 again
    D_rr = 4'b1001; q_rr.push_back(0); q_rr.push_back(3);
    tick(); D_rr = 4'b0; repeat (3) tick();

    // Fixed priority: 1011 -> 3,1,0
    D_fx = 4'b1011; ready_fx = 1'b1; q_fx.push_back(3); q_fx.push_back(1); q_fx.push_back(0);
    tick(); D_fx = 4'b0;
    tick();
    chk("fx_first_A", int'(A_fx), 3);
    repeat (2) tick();
    tick();
    chk("fx_idle", int'(valid_fx), 0);

    // Same-line set and clear: set wins, no overflow
    D_fx = 4'b0100; q_fx.push_back(2); q_fx.push_back(2);
    tick(); D_fx = 4'b0; tick();
    chk("sw_valid", int'(valid_fx), 1);
    D_fx = 4'b0100;
    tick(); D_fx = 4'b0;
    chk("sw_cnt", int'(cnt_fx), 1);
    chk("sw_valid_idle", int'(valid_fx), 0);
    chk("sw_ovf", int'(ovf_fx), 0);
    tick(); tick();
    chk("sw_done_cnt", int'(cnt_fx), 0);

    // Backpressure: ptr=0, 0011 -> 0 held, then 1
    ready_rr = 1'b0; D_rr = 4'b0011; q_rr.push_back(0); q_rr.push_back(1);
    tick(); D_rr = 4'b0; tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_A", int'(A_rr), 0);
      chk("bp_valid", int'(valid_rr), 1);
      chk("bp_cnt", int'(cnt_rr), 2);
      chk("bp_multi", int'(multi_rr), 1);
      tick();
    end
    ready_rr = 1'b1;
    tick();
    chk("bp_next_A", int'(A_rr), 1);
    chk("bp_next_multi", int'(multi_rr), 0);
    tick();
    chk("bp_idle", int'(valid_rr), 0);

    // Overflow: ptr=2, line 0 pulsed twice under backpressure
    ready_rr = 1'b0; D_rr = 4'b0001;
    tick();
    chk("ovf_first", int'(ovf_rr), 0);
    tick(); D_rr = 4'b0;
    chk("ovf_set", int'(ovf_rr), 1);
    chk("ovf_cnt", int'(cnt_rr), 1);
    tick(); tick();
    chk("ovf_sticky", int'(ovf_rr), 1);
    ready_rr = 1'b1; q_rr.push_back(0);
    tick();
    chk("ovf_after_hs_valid", int'(valid_rr), 0);
    chk("ovf_after_hs", int'(ovf_rr), 1);

    // Reset mid-grant: ptr=1, 1101 -> A=2, cnt=3
    ready_rr = 1'b0; D_rr = 4'b1101;
    tick(); D_rr = 4'b0; tick();
    chk("mid_valid", int'(valid_rr), 1);
    chk("mid_A", int'(A_rr), 2);
    chk("mid_cnt", int'(cnt_rr), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(valid_rr), 0);
    chk("arst_A", int'(A_rr), 0);
    chk("arst_cnt", int'(cnt_rr), 0);
    chk("arst_ovf", int'(ovf_rr), 0);
    tick();
    rst_n = 1'b1;
    // First edge after release samples D; ptr back to 0
    D_rr = 4'b0110; ready_rr = 1'b1; q_rr.push_back(1); q_rr.push_back(2);
    tick(); D_rr = 4'b0;
    chk("post_rst_cnt", int'(cnt_rr), 2);
    tick();
    chk("post_rst_A", int'(A_rr), 1);
    repeat (3) tick();

    chk("rr_queue_drained", q_rr.size(), 0);
    chk("fx_queue_drained", q_fx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/encoder4to2_rr.md
ENCODER4TO2_RR -- requirements
Module: encoder4to2_rr

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (highest index wins).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 D  input  4  request pulses, one bit per line; a bit high at a rising edge posts one request for that line.
REQ-006 ready  input  1  consumer accepts A this cycle when valid is high.
REQ-007 A  output  2  binary index of the granted line, registered.
REQ-008 valid  output  1  A holds a granted request, registered.
REQ-009 cnt  output  3  popcount of the pending register, 0..4.
REQ-010 multi  output  1  high when cnt > 1.
REQ-011 ovf  output  1  sticky flag: a request was lost.

Function
REQ-012 Pending register pend[3:0] SHALL update every edge as pend <= (pend & ~clr) | D; clr = one-hot of A when valid & ready, else 0.
REQ-013 Same-line set and clear in one cycle: set SHALL win (bit stays 1, counted as new request).
REQ-014 D bit high while the same pend bit is 1 and not being cleared SHALL set ovf on that edge; the request is dropped; ovf holds until reset.
REQ-015 FSM states: IDLE (valid=0), GRANT (valid=1).
REQ-016 IDLE -> GRANT when pend != 0: A <= selected index, valid <= 1.
REQ-017 GRANT with ready=0: A and valid SHALL hold unchanged; pend bits may still set.
REQ-018 GRANT with ready=1: if (pend & ~clr) != 0, stay GRANT and load A with next selection from (pend & ~clr) using the updated pointer; else -> IDLE, valid <= 0. D in the same cycle is not considered for that selection.
REQ-019 Round-robin (RR_EN=1): 2-bit pointer ptr; search order ptr, ptr+1, ptr+2, ptr+3 mod 4; first set bit wins.
REQ-020 On each handshake of index i, ptr <= (i+1) mod 4; i=3 SHALL wrap to 0.
REQ-021 Fixed mode (RR_EN=0): highest set index wins; ptr unused.
REQ-022 Latency: D pulse at edge k on an idle block with pend=0 SHALL give valid=1 with A=index after edge k+1.
REQ-023 Back-to-back throughput: one grant per cycle while ready=1 and requests remain.
REQ-024 cnt and multi SHALL be combinational from registered pend only.
REQ-025 Granted line remains set in pend (and in cnt) until its handshake edge.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, pend=0, ptr=0, A=0, valid=0, ovf=0, cnt=0, multi=0.
REQ-027 Reset mid-grant SHALL drop valid asynchronously and discard all pending requests; no handshake is reported.
REQ-028 First edge after rst_n deasserts SHALL sample D normally.

Verification
REQ-029 Single request: D=4'b0100 for one cycle, ready=1 -> valid=1, A=2 after edge k+1; valid=0 one cycle later; cnt back to 0.
REQ-030 Round-robin order: RR_EN=1, D=4'b1111 one pulse, ready=1 -> A sequence 0,1,2,3 on consecutive cycles, then valid=0; ptr wraps to 0.
REQ-031 Fixed priority: RR_EN=0, D=4'b1011 one pulse, ready=1 -> A sequence 3,1,0.
REQ-032 Backpressure: D=4'b0011, ready=0 for 5 cycles -> A=0 held stable, valid=1, cnt=2, multi=1; ready=1 -> A=1 next cycle.
REQ-033 Overflow: D=4'b0001 twice while ready=0 -> ovf=1 after second edge, cnt=1; ovf stays 1 until rst_n low.
REQ-034 Reset mid-grant: valid=1, A=2, cnt=3, drop rst_n between edges -> valid, A, cnt, ovf all 0 without waiting for clk.
